// File: rtl/key_press_classifier_if.sv
// Button-side bundle of key_press_classifier: raw key input plus the debounced
// level and the short/long event pulses.
interface key_press_classifier_if;
  logic key_in;
  logic key_short;
  logic key_long;
  logic key_pressed;

  modport master (output key_in, input key_short, key_long, key_pressed);
  modport slave  (input key_in, output key_short, key_long, key_pressed);
endinterface

// File: rtl/key_press_classifier.sv
// Raw push-button -> 2-FF sync -> debounce FSM -> press-duration classifier.
// Emits one registered key_short or key_long pulse per accepted press.
module key_press_classifier #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input logic clk,
  input logic rst,
  key_press_classifier_if.slave kif
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic REL_LVL = (KEY_ACTIVE_LOW != 0);
  localparam bit DEB_ONE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [2:0] {IDLE, DEB_PRESS, PRESSED, LONG_HELD, DEB_REL} state_t;

  state_t state, state_nxt;
  logic [DW-1:0] deb_cnt, deb_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic ret_long, ret_long_nxt;
  logic [1:0] sync_pipe;
  logic pressed_s;
  logic short_set, long_set, pressed_nxt;
  logic key_short_q, key_long_q, key_pressed_q;

  // Sync flops hold the raw pin level, so their reset value is the released level.
  assign pressed_s = sync_pipe[1] ^ REL_LVL;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pipe     <= {2{REL_LVL}};
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      ret_long      <= 1'b0;
      key_short_q   <= 1'b0;
      key_long_q    <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      sync_pipe     <= {sync_pipe[0], kif.key_in};
      state         <= state_nxt;
      deb_cnt       <= deb_nxt;
      hold_cnt      <= hold_nxt;
      ret_long      <= ret_long_nxt;
      key_short_q   <= short_set;
      key_long_q    <= long_set;
      key_pressed_q <= pressed_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    deb_nxt      = deb_cnt;
    hold_nxt     = hold_cnt;
    ret_long_nxt = ret_long;
    case (state)
      IDLE: if (pressed_s) begin
        if (DEB_ONE) begin
          state_nxt = PRESSED;
          hold_nxt  = '0;
        end else begin
          state_nxt = DEB_PRESS;
          deb_nxt   = DW'(1);
        end
      end
      DEB_PRESS: begin
        if (!pressed_s) begin
          state_nxt = IDLE;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          deb_nxt   = '0;
          hold_nxt  = '0;
        end else if (deb_cnt < DEB_LAST) begin
          deb_nxt = deb_cnt + DW'(1);
        end
      end
      PRESSED: begin
        if (pressed_s) begin
          if (hold_cnt < HW'(LONG_CYCLES)) hold_nxt = hold_cnt + HW'(1);
          if (hold_cnt == HOLD_LAST) state_nxt = LONG_HELD;
        end else if (DEB_ONE) begin
          state_nxt = IDLE;
        end else begin
          state_nxt    = DEB_REL;
          deb_nxt      = DW'(1);
          ret_long_nxt = 1'b0;
        end
      end
      LONG_HELD: if (!pressed_s) begin
        if (DEB_ONE) begin
          state_nxt = IDLE;
        end else begin
          state_nxt    = DEB_REL;
          deb_nxt      = DW'(1);
          ret_long_nxt = 1'b1;
        end
      end
      DEB_REL: begin
        // A high sample here is a release glitch: resume the press, hold_cnt untouched.
        if (pressed_s) begin
          state_nxt = ret_long ? LONG_HELD : PRESSED;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = IDLE;
          deb_nxt   = '0;
        end else if (deb_cnt < DEB_LAST) begin
          deb_nxt = deb_cnt + DW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    short_set   = 1'b0;
    long_set    = 1'b0;
    pressed_nxt = (state_nxt == PRESSED) || (state_nxt == LONG_HELD) || (state_nxt == DEB_REL);
    if (state == DEB_REL && !pressed_s && deb_cnt == DEB_LAST && !ret_long) short_set = 1'b1;
    if (DEB_ONE && state == PRESSED && !pressed_s) short_set = 1'b1;
    if (state == PRESSED && pressed_s && hold_cnt == HOLD_LAST) long_set = 1'b1;
  end

  assign kif.key_short   = key_short_q;
  assign kif.key_long    = key_long_q;
  assign kif.key_pressed = key_pressed_q;
endmodule

// File: tb/tb_key_press_classifier.sv
// Random + directed bench for key_press_classifier against a run-length model
// of the debounce/duration rules, plus literal edge checks for the key scenarios.
module tb_key_press_classifier;
  localparam int D = 4;
  localparam int L = 10;

  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;

  key_press_classifier_if kif();

  key_press_classifier #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .KEY_ACTIVE_LOW(0)) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  // Model: level flips after D consecutive opposite synced samples; hold time
  // counts only samples taken while settled pressed; one event per press.
  bit [1:0] hist;
  bit level, fired, m_short, m_long, ps;
  int run, hold;

  always @(posedge clk) begin
    m_short = 1'b0;
    m_long  = 1'b0;
    if (rst) begin
      hist = 2'b00; level = 1'b0; fired = 1'b0; run = 0; hold = 0;
    end else begin
      ps   = hist[1];
      hist = {hist[0], kif.key_in};
      if (!level) begin
        if (ps) begin
          run++;
          if (run == D) begin level = 1'b1; run = 0; hold = 0; fired = 1'b0; end
        end else run = 0;
      end else if (!ps) begin
        run++;
        if (run == D) begin
          level = 1'b0; run = 0;
          if (!fired) m_short = 1'b1;
        end
      end else if (run > 0) begin
        run = 0;
      end else if (!fired) begin
        hold++;
        if (hold == L) begin m_long = 1'b1; fired = 1'b1; end
      end
    end
    #1;
    chk("model_short", kif.key_short, m_short);
    chk("model_long", kif.key_long, m_long);
    chk("model_pressed", kif.key_pressed, level);
  end

  task automatic tick(input logic k, input logic r);
    @(negedge clk);
    kif.key_in = k;
    rst = r;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    kif.key_in = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      chk("rst_short", kif.key_short, 1'b0);
      chk("rst_long", kif.key_long, 1'b0);
      chk("rst_pressed", kif.key_pressed, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      chk("post_rst_pressed", kif.key_pressed, 1'b0);
    end

    for (int e = 0; e < 20; e++) begin
      tick(e <= 7, 1'b0);
      chk("short_ks", kif.key_short, e == 13);
      chk("short_kl", kif.key_long, 1'b0);
      chk("short_kp", kif.key_pressed, e >= 5 && e < 13);
    end
    idle(10);

    for (int e = 0; e < 46; e++) begin
      tick(e < 30, 1'b0);
      chk("long_kl", kif.key_long, e == 15);
      chk("long_ks", kif.key_short, 1'b0);
      chk("long_kp", kif.key_pressed, e >= 5 && e < 35);
    end
    idle(10);

    for (int e = 0; e < 16; e++) begin
      tick(e < 2, 1'b0);
      chk("pbounce_ks", kif.key_short, 1'b0);
      chk("pbounce_kl", kif.key_long, 1'b0);
      chk("pbounce_kp", kif.key_pressed, 1'b0);
    end
    idle(5);

    for (int e = 0; e < 26; e++) begin
      tick(e <= 5 || (e >= 8 && e <= 11), 1'b0);
      chk("rbounce_ks", kif.key_short, e == 17);
      chk("rbounce_kl", kif.key_long, 1'b0);
      chk("rbounce_kp", kif.key_pressed, e >= 5 && e < 17);
    end
    idle(10);

    for (int e = 0; e < 36; e++) begin
      tick(1'b1, e == 10);
      chk("rstmid_kl", kif.key_long, e == 26);
      chk("rstmid_ks", kif.key_short, 1'b0);
      chk("rstmid_kp", kif.key_pressed, (e >= 5 && e < 10) || e >= 16);
    end
    idle(15);

    for (int s = 0; s < 300; s++) begin
      logic lvl;
      int len;
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) tick(lvl, $urandom_range(0, 60) == 0);
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_press_classifier.md
Name: key_press_classifier

Overview:
- Converts a raw, bouncing push-button input into the one-cycle key_short / key_long event pulses consumed by the clock state machine.
- Also provides the debounced key level.
- Chain: raw key_in -> 2-FF synchroniser -> debounce FSM -> press-duration classifier -> registered event pulses.
- Sits between the board button pin and clock_sm in the digital clock top level.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive identical synchronised samples needed to accept a press or a release (10 ms at 50 MHz); legal range >= 1.
- LONG_CYCLES, 50000000: cycles in PRESSED after which the press is long (1 s at 50 MHz); legal range >= 1.
- KEY_ACTIVE_LOW, 1: 1 = key_in low means pressed; 0 = key_in high means pressed.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_in  in  1  raw asynchronous button input
- key_short  out  1  one-cycle pulse: press released before LONG_CYCLES
- key_long  out  1  one-cycle pulse: press held for LONG_CYCLES
- key_pressed  out  1  debounced key level (1 = pressed)

Behaviour:
- Reset: one clock, synchronous, active-high; rst sampled high at a rising edge clears everything. After reset:
  - FSM = IDLE; all counters 0.
  - Synchroniser flops = released level.
  - key_short = key_long = key_pressed = 0.
  - Reset mid-operation abandons any press; no pulse is emitted for it.
  - A key still held after rst deasserts is treated as a new press and needs full debounce.
- Synchroniser: 2 flops. pressed_s = synchronised key_in at the active level. Latency from key_in to pressed_s = 2 edges.
- Counters:
  - deb_cnt width = $clog2(DEBOUNCE_CYCLES+1).
  - hold_cnt width = $clog2(LONG_CYCLES+1).
  - Both saturating; never wrap.
- FSM states and transitions:
  - IDLE: pressed_s=1 -> DEB_PRESS, deb_cnt=1.
  - DEB_PRESS:
    - pressed_s=0 -> IDLE, deb_cnt=0.
    - pressed_s=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> PRESSED, hold_cnt=0, key_pressed<=1.
    - Otherwise deb_cnt++.
    - With DEBOUNCE_CYCLES=1, IDLE goes directly to PRESSED.
  - PRESSED:
    - pressed_s=1: hold_cnt++. When hold_cnt reaches LONG_CYCLES -> key_long<=1 for one cycle; -> LONG_HELD.
    - pressed_s=0 -> DEB_REL, deb_cnt=1, ret=PRESSED.
  - LONG_HELD: pressed_s=0 -> DEB_REL, deb_cnt=1, ret=LONG_HELD. No further pulses while held (no auto-repeat).
  - DEB_REL:
    - pressed_s=1 -> back to ret; hold_cnt frozen during DEB_REL and resumes. The glitch is ignored.
    - pressed_s=0 and deb_cnt==DEBOUNCE_CYCLES-1:
      - -> IDLE; key_pressed<=0.
      - If ret==PRESSED, key_short<=1 for one cycle.
      - If ret==LONG_HELD, no pulse.
    - Otherwise deb_cnt++.
- Pulses:
  - key_short and key_long are registered outputs, high exactly one cycle per press.
  - They are never high in the same cycle.
  - At most one event per press.
- Press shorter than DEBOUNCE_CYCLES samples: produces no output change.

Test Plan:
- Common setup for all scenarios:
  - DEBOUNCE_CYCLES=4, LONG_CYCLES=10, KEY_ACTIVE_LOW=0.
  - Edge 0 = first rising edge sampling key_in=1.
- Reset: rst=1 for 3 cycles with key_in=0 -> key_short=key_long=key_pressed=0 at every edge during and after reset.
- Short press:
  - Stimulus: key_in=1 for edges 0..7, then 0.
  - key_pressed rises after edge 5.
  - key_short high only between edges 13 and 14.
  - key_pressed falls after edge 13; key_long never asserted.
- Long press:
  - Stimulus: key_in=1 for 30 cycles, then 0.
  - key_pressed rises after edge 5.
  - key_long high only between edges 15 and 16.
  - key_short never asserted, including after release; key_pressed falls 6 edges after key_in falls.
- Press bounce: key_in=1 for 2 cycles, then 0 -> no pulses; key_pressed stays 0.
- Release bounce:
  - Stimulus: press as in the short-press case, but key_in low for only 2 cycles at edge 6, then high, then released.
  - Exactly one key_short, after the final release plus 6 edges.
  - key_pressed never drops during the glitch.
- Reset mid-press:
  - Stimulus: key_in held high; rst=1 for one cycle at edge 10 (hold_cnt=4).
  - No key_long near edge 15.
  - With the key still high, key_pressed rises again 6 edges after rst deasserts.
  - key_long fires 10 edges after that.
